data_memory_unit: RTL and testbench

Parametrised pipelined data memory for the 20-bit pipelined core, replacing the single-cycle data memory used in the datapath unit. It provides word/byte accesses with configurable read latency and a read-valid strobe, and a stall output for the hazard unit. It also has a streaming dump port that lets a bench or debug host read the whole memory through a valid/ready handshake, so benches no longer need hierarchical peeks into the array.

---
 rtl/data_memory_unit.sv | 152 +++++++++++++++
 tb/tb_data_memory_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// Pipelined word/byte data memory with configurable read latency, a stall output
// for the hazard unit and a valid/ready streaming dump port for whole-array readout.
module data_memory_unit #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE      = 256,
    parameter int BYTE_WIDTH    = 8,
    parameter int READ_LATENCY  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic                     ByteEnable,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic [DATA_WIDTH-1:0]    mem_read_data,
    output logic                     read_valid,
    output logic                     mem_busy,
    input  logic                     dump_start,
    input  logic                     dump_ready,
    output logic                     dump_valid,
    output logic [ADDRESS_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0]    dump_data,
    output logic                     dump_done
);

    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEM_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_DUMP,
        S_DONE
    } state_t;

    state_t state;

    logic [DATA_WIDTH-1:0]   mem [MEM_SIZE];
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        dump_idx;
    logic                    in_range;
    logic                    rd_accept;
    logic                    wr_accept;
    logic [DATA_WIDTH-1:0]   word;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [READ_LATENCY-1:0] vpipe;
    logic [DATA_WIDTH-1:0]   dpipe [READ_LATENCY];
    logic                    pipe_busy;

    assign idx       = address[IDX_W-1:0];
    assign dump_idx  = dump_addr[IDX_W-1:0];
    assign in_range  = int'(address) < MEM_SIZE;
    assign rd_accept = MemRead && !mem_busy;
    assign wr_accept = MemWrite && !mem_busy && in_range;
    assign word      = mem[idx];
    assign pipe_busy = |vpipe;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rdata = '0;
        if (in_range) begin
            if (ByteEnable)
                rdata = {{(DATA_WIDTH - BYTE_WIDTH){1'b0}}, word[BYTE_WIDTH-1:0]};
            else
                rdata = word;
        end
    end

    // NOTE: the storage array has no reset; only control state and outputs are cleared.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            if (ByteEnable)
                mem[idx][BYTE_WIDTH-1:0] <= mem_write_data[BYTE_WIDTH-1:0];
            else
                mem[idx] <= mem_write_data;
        end
    end

    // Data stages only advance behind a valid, so the last stage holds the previous result.
    // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vpipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) dpipe[i] <= '0;
        end else begin
            vpipe[0] <= rd_accept;
            if (rd_accept) dpipe[0] <= rdata;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vpipe[i] <= vpipe[i-1];
                if (vpipe[i-1]) dpipe[i] <= dpipe[i-1];
            end
        end
    end

    assign read_valid    = vpipe[READ_LATENCY-1];
    assign mem_read_data = dpipe[READ_LATENCY-1];

    // Writes are blocked while busy, so an asynchronous array read stays coherent across the dump.
    assign dump_data = dump_valid ? mem[dump_idx] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            mem_busy   <= 1'b0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dump_start) begin
                        mem_busy <= 1'b1;
                        // A read accepted this very cycle is also in flight.
                        if (pipe_busy || rd_accept) begin
                            state <= S_DRAIN;
                        end else begin
                            state      <= S_DUMP;
                            dump_valid <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!pipe_busy) begin
                        state      <= S_DUMP;
                        dump_valid <= 1'b1;
                    end
                end
                S_DUMP: begin
                    if (dump_ready) begin
                        if (dump_addr == LAST_ADDR) begin
                            state      <= S_DONE;
                            dump_valid <= 1'b0;
                            dump_done  <= 1'b1;
                            dump_addr  <= '0;
                        end else begin
                            dump_addr <= dump_addr + ADDRESS_WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    dump_done <= 1'b0;
                    mem_busy  <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench: instance a (latency 2, 256 words) covers the read/write path;
// instance b (latency 3, 16 words) covers out-of-range, drain, dump and reset behaviour.
module tb_data_memory_unit;

    logic clk;
    logic rst;

    logic        a_re, a_we, a_be;
    logic [7:0]  a_addr;
    logic [19:0] a_wdata, a_rdata;
    logic        a_rv, a_busy, a_start, a_ready, a_dv, a_done;
    logic [7:0]  a_daddr;
    logic [19:0] a_ddata;

    logic        b_re, b_we, b_be;
    logic [7:0]  b_addr;
    logic [19:0] b_wdata, b_rdata;
    logic        b_rv, b_busy, b_start, b_ready, b_dv, b_done;
    logic [7:0]  b_daddr;
    logic [19:0] b_ddata;

    logic [19:0] exp_b [16];
    int n_checks = 0;
    int n_errors = 0;
    int k;

    data_memory_unit #(
        .DATA_WIDTH(20), .ADDRESS_WIDTH(8), .MEM_SIZE(256), .BYTE_WIDTH(8), .READ_LATENCY(2)
    ) dut_a (
        .clk(clk), .rst(rst),
        .MemRead(a_re), .MemWrite(a_we), .ByteEnable(a_be), .address(a_addr),
        .mem_write_data(a_wdata), .mem_read_data(a_rdata), .read_valid(a_rv),
        .mem_busy(a_busy), .dump_start(a_start), .dump_ready(a_ready),
        .dump_valid(a_dv), .dump_addr(a_daddr), .dump_data(a_ddata), .dump_done(a_done)
    );

    data_memory_unit #(
        .DATA_WIDTH(20), .ADDRESS_WIDTH(8), .MEM_SIZE(16), .BYTE_WIDTH(8), .READ_LATENCY(3)
    ) dut_b (
        .clk(clk), .rst(rst),
        .MemRead(b_re), .MemWrite(b_we), .ByteEnable(b_be), .address(b_addr),
        .mem_write_data(b_wdata), .mem_read_data(b_rdata), .read_valid(b_rv),
        .mem_busy(b_busy), .dump_start(b_start), .dump_ready(b_ready),
        .dump_valid(b_dv), .dump_addr(b_daddr), .dump_data(b_ddata), .dump_done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [7:0] addr, input logic be, input logic [19:0] d);
        a_we = 1'b1; a_addr = addr; a_be = be; a_wdata = d;
        tick();
        a_we = 1'b0; a_be = 1'b0;
    endtask

    task automatic b_write(input logic [7:0] addr, input logic be, input logic [19:0] d);
        b_we = 1'b1; b_addr = addr; b_be = be; b_wdata = d;
        tick();
        b_we = 1'b0; b_be = 1'b0;
    endtask

    task automatic a_read_check(input string tag, input logic [7:0] addr, input logic be,
                                input logic [19:0] exp);
        a_re = 1'b1; a_addr = addr; a_be = be;
        tick();
        a_re = 1'b0; a_be = 1'b0;
        check({tag, "_early"}, a_rv, 0);
        tick();
        check({tag, "_valid"}, a_rv, 1);
        check({tag, "_data"}, a_rdata, exp);
        tick();
        check({tag, "_once"}, a_rv, 0);
        check({tag, "_hold"}, a_rdata, exp);
    endtask

    task automatic b_read_check(input string tag, input logic [7:0] addr, input logic be,
                                input logic [19:0] exp);
        b_re = 1'b1; b_addr = addr; b_be = be;
        tick();
        b_re = 1'b0; b_be = 1'b0;
        check({tag, "_early1"}, b_rv, 0);
        tick();
        check({tag, "_early2"}, b_rv, 0);
        tick();
        check({tag, "_valid"}, b_rv, 1);
        check({tag, "_data"}, b_rdata, exp);
        tick();
        check({tag, "_once"}, b_rv, 0);
    endtask

    initial begin
        rst = 1'b0;
        a_re = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0; a_start = 0; a_ready = 0;
        b_re = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0; b_start = 0; b_ready = 0;
        for (int i = 0; i < 16; i++) exp_b[i] = 20'(32'h0A000 + i * 32'h111);

        tick(); tick();
        check("rst_a_rdata", a_rdata, 0);
        check("rst_a_rv", a_rv, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_b_dv", b_dv, 0);
        check("rst_b_daddr", b_daddr, 0);
        check("rst_b_ddata", b_ddata, 0);
        check("rst_b_done", b_done, 0);
        check("rst_b_busy", b_busy, 0);
        #2 rst = 1'b1;
        tick();

        // Latency-2 word read of a freshly written word
        a_write(8'h10, 1'b0, 20'hABCDE);
        a_read_check("lat2", 8'h10, 1'b0, 20'hABCDE);

        // Byte write only touches the low byte; upper write-data bits are junk on purpose
        a_write(8'h20, 1'b0, 20'hFFFFF);
        a_write(8'h20, 1'b1, 20'h3C35A);
        a_read_check("byte_word", 8'h20, 1'b0, 20'hFFF5A);
        a_read_check("byte_read", 8'h20, 1'b1, 20'h0005A);

        // Back-to-back reads
        a_write(8'h01, 1'b0, 20'd1);
        a_write(8'h02, 1'b0, 20'd2);
        a_write(8'h03, 1'b0, 20'd3);
        a_write(8'h05, 1'b0, 20'd7);
        a_re = 1'b1; a_addr = 8'h01;
        tick();
        check("b2b_early", a_rv, 0);
        a_addr = 8'h02;
        tick();
        check("b2b_v1", a_rv, 1); check("b2b_d1", a_rdata, 1);
        a_addr = 8'h03;
        tick();
        a_re = 1'b0;
        check("b2b_v2", a_rv, 1); check("b2b_d2", a_rdata, 2);
        tick();
        check("b2b_v3", a_rv, 1); check("b2b_d3", a_rdata, 3);
        tick();
        check("b2b_end", a_rv, 0);

        // Same-cycle read and write returns the old word
        a_re = 1'b1; a_we = 1'b1; a_addr = 8'h05; a_wdata = 20'd9; a_be = 1'b0;
        tick();
        a_re = 1'b0; a_we = 1'b0;
        tick();
        check("rbw_valid", a_rv, 1);
        check("rbw_old", a_rdata, 7);
        tick();
        a_read_check("rbw_new", 8'h05, 1'b0, 20'd9);

        // Fill instance b, then exercise an out-of-range address
        for (int i = 0; i < 16; i++) b_write(8'(i), 1'b0, exp_b[i]);
        b_write(8'h20, 1'b0, 20'h12345);
        b_read_check("oor", 8'h20, 1'b0, 20'h0);
        b_read_check("oor_no_alias", 8'h00, 1'b0, exp_b[0]);

        // Dump requested one cycle after a read: drain first
        b_re = 1'b1; b_addr = 8'h03;
        tick();
        b_re = 1'b0; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("drain_busy0", b_busy, 1); check("drain_dv0", b_dv, 0); check("drain_rv0", b_rv, 0);
        tick();
        check("drain_rv", b_rv, 1); check("drain_data", b_rdata, exp_b[3]);
        check("drain_busy1", b_busy, 1); check("drain_dv1", b_dv, 0);
        tick();
        check("drain_busy2", b_busy, 1); check("drain_dv2", b_dv, 0);
        tick();
        check("dump_rise", b_dv, 1); check("dump_busy", b_busy, 1);

        // Toggled ready, with writes, reads and a stray dump_start that must all be ignored
        k = 0;
        for (int c = 0; c < 100; c++) begin
            b_ready = (c % 2 == 0);
            b_start = (c == 3);
            b_we = 1'b1; b_re = 1'b1; b_addr = 8'h05; b_wdata = 20'hBEEF0;
            check("beat_valid", b_dv, 1);
            check("beat_addr", b_daddr, k);
            check("beat_data", b_ddata, exp_b[k]);
            check("beat_rv", b_rv, 0);
            check("beat_done", b_done, 0);
            if (b_ready) k++;
            tick();
            if (k == 16) break;
        end
        b_we = 1'b0; b_re = 1'b0; b_ready = 1'b0; b_start = 1'b0;
        check("dump_beats", k, 16);
        check("done_pulse", b_done, 1);
        check("done_dv", b_dv, 0);
        check("done_busy", b_busy, 1);
        check("done_addr", b_daddr, 0);
        tick();
        check("done_once", b_done, 0);
        check("done_idle", b_busy, 0);
        b_read_check("post_dump_5", 8'h05, 1'b0, exp_b[5]);

        // Async reset in the middle of a dump
        b_start = 1'b1; b_ready = 1'b1;
        tick();
        b_start = 1'b0;
        check("start_dv", b_dv, 1); check("start_busy", b_busy, 1); check("start_addr", b_daddr, 0);
        tick(); tick(); tick();
        check("mid_addr", b_daddr, 3);
        #2 rst = 1'b0;
        #1;
        check("arst_dv", b_dv, 0); check("arst_daddr", b_daddr, 0);
        check("arst_ddata", b_ddata, 0); check("arst_busy", b_busy, 0);
        check("arst_done", b_done, 0); check("arst_a_rdata", a_rdata, 0);
        #1 rst = 1'b1;
        tick();
        check("post_arst_dv", b_dv, 0);

        // Restart from address 0 with ready held high
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("rs_valid", b_dv, 1);
            check("rs_addr", b_daddr, i);
            check("rs_data", b_ddata, exp_b[i]);
            tick();
        end
        check("rs_done", b_done, 1);
        check("rs_busy_done", b_busy, 1);
        tick();
        check("rs_busy_low", b_busy, 0);
        b_ready = 1'b0;

        // Async reset with two reads in flight
        b_re = 1'b1; b_addr = 8'h01;
        tick();
        b_addr = 8'h02; b_start = 1'b1;
        tick();
        b_re = 1'b0; b_start = 1'b0;
        check("inflight_rv", b_rv, 0); check("inflight_busy", b_busy, 1);
        #2 rst = 1'b0;
        #1;
        check("arst2_busy", b_busy, 0); check("arst2_rv", b_rv, 0); check("arst2_rdata", b_rdata, 0);
        #1 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("dropped_rv", b_rv, 0);
            check("dropped_dv", b_dv, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
